// File: rtl/icache_refill_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read-shim port among instruction-cache refill requesters.
// Holds the AR channel stable until granted, throttles bursts in flight and routes beats back by ID.
module icache_refill_rd_arbiter #(
    parameter int NumReq         = 2,
    parameter int AddrWidth      = 64,
    parameter int BlenWidth      = 2,
    parameter int AxiIdWidth     = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               req_i,
    output logic [NumReq-1:0]               gnt_o,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq*BlenWidth-1:0]     blen_i,
    output logic [NumReq-1:0]               rd_valid_o,
    output logic                            rd_last_o,
    output logic [63:0]                     rd_data_o,
    output logic                            rd_req_o,
    input  logic                            rd_gnt_i,
    output logic [AddrWidth-1:0]            rd_addr_o,
    output logic [BlenWidth-1:0]            rd_blen_o,
    output logic [AxiIdWidth-1:0]           rd_id_o,
    input  logic                            rd_valid_i,
    input  logic                            rd_last_i,
    input  logic [63:0]                     rd_data_i,
    input  logic [AxiIdWidth-1:0]           rd_rid_i,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [CntW-1:0]       MAX_OUT  = CntW'(MaxOutstanding);
    localparam logic [IdxW-1:0]       LAST_IDX = IdxW'(NumReq - 1);
    localparam logic [AxiIdWidth-1:0] NUM_ID   = AxiIdWidth'(NumReq);

    generate
        if (NumReq < 2) begin : g_bad_numreq
            $error("NumReq must be at least 2");
        end
        if (AxiIdWidth < IdxW) begin : g_bad_idw
            $error("AxiIdWidth too narrow to carry the requester index");
        end
        if (MaxOutstanding < 1 || MaxOutstanding > 15) begin : g_bad_maxout
            $error("MaxOutstanding must be within 1..15");
        end
    endgenerate

    logic [0:0]      state_q, state_d;
    logic [IdxW-1:0] rr_q,    rr_d;
    logic [IdxW-1:0] idx_q,   idx_d;
    logic [CntW-1:0] cnt_q,   cnt_d;
    logic            err_q,   err_d;

    logic            can_issue;
    logic            arb_found;
    logic [IdxW-1:0] arb_idx;
    logic [IdxW-1:0] sel_idx;
    logic            req_active;
    logic            ar_fire;
    logic            r_done;
    int unsigned     cand;

    // First requester at or after the round-robin pointer, wrapping once around.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        arb_found = 1'b0;
        arb_idx   = rr_q;
        cand      = 0;
        for (int i = 0; i < NumReq; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!arb_found && req_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IdxW'(cand);
            end
        end
    end

    assign can_issue  = arb_found && (cnt_q < MAX_OUT);
    assign sel_idx    = (state_q == HOLD) ? idx_q : arb_idx;
    assign req_active = rst_ni && ((state_q == HOLD) || can_issue);
    assign ar_fire    = req_active && rd_gnt_i;
    assign r_done     = rd_valid_i && rd_last_i;

    // AR channel: driven from the selected requester, quiet whenever nothing is requested.
    always_comb begin
        rd_req_o  = req_active;
        rd_addr_o = '0;
        rd_blen_o = '0;
        rd_id_o   = '0;
        gnt_o     = '0;
        if (req_active) begin
            rd_id_o = AxiIdWidth'(sel_idx);
            for (int i = 0; i < NumReq; i++) begin
                if (sel_idx == IdxW'(i)) begin
                    rd_addr_o = addr_i[i*AddrWidth +: AddrWidth];
                    rd_blen_o = blen_i[i*BlenWidth +: BlenWidth];
                    gnt_o[i]  = rd_gnt_i;
                end
            end
        end
    end

    // R channel: beat valid routed by ID, data and last broadcast.
    always_comb begin
        rd_valid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            rd_valid_o[i] = rst_ni && rd_valid_i && (rd_rid_i == AxiIdWidth'(i));
        end
    end

    assign rd_data_o = rst_ni ? rd_data_i : '0;
    assign rd_last_o = rst_ni && rd_last_i;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    idx_d = arb_idx;
                    if (!rd_gnt_i) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (rd_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ar_fire) begin
            rr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + IdxW'(1);
        end

        // A last beat with nothing outstanding is a protocol error; the count saturates at zero.
        if (ar_fire && !r_done) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (r_done && !ar_fire && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end

        if (rd_valid_i && (rd_rid_i >= NUM_ID)) begin
            err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = rst_ni && ((cnt_q != '0) || (state_q == HOLD));
    assign err_o  = err_q;

endmodule

// File: tb/tb_icache_refill_rd_arbiter.sv
// Directed bench for icache_refill_rd_arbiter with two requesters and four bursts in flight.
// Inputs change just after the rising edge; outputs are sampled shortly after, mid-cycle.
module tb_icache_refill_rd_arbiter;

    localparam int NumReq    = 2;
    localparam int AddrWidth = 64;
    localparam int BlenWidth = 2;
    localparam int IdW       = 4;

    logic                        clk_i = 1'b0;
    logic                        rst_ni;
    logic [NumReq-1:0]           req_i;
    logic [NumReq-1:0]           gnt_o;
    logic [NumReq*AddrWidth-1:0] addr_i;
    logic [NumReq*BlenWidth-1:0] blen_i;
    logic [NumReq-1:0]           rd_valid_o;
    logic                        rd_last_o;
    logic [63:0]                 rd_data_o;
    logic                        rd_req_o;
    logic                        rd_gnt_i;
    logic [AddrWidth-1:0]        rd_addr_o;
    logic [BlenWidth-1:0]        rd_blen_o;
    logic [IdW-1:0]              rd_id_o;
    logic                        rd_valid_i;
    logic                        rd_last_i;
    logic [63:0]                 rd_data_i;
    logic [IdW-1:0]              rd_rid_i;
    logic                        busy_o;
    logic                        err_o;

    int total = 0;
    int bad   = 0;

    icache_refill_rd_arbiter #(
        .NumReq(NumReq), .AddrWidth(AddrWidth), .BlenWidth(BlenWidth),
        .AxiIdWidth(IdW), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .blen_i(blen_i), .rd_valid_o(rd_valid_o),
        .rd_last_o(rd_last_o), .rd_data_o(rd_data_o), .rd_req_o(rd_req_o),
        .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o), .rd_blen_o(rd_blen_o),
        .rd_id_o(rd_id_o), .rd_valid_i(rd_valid_i), .rd_last_i(rd_last_i),
        .rd_data_i(rd_data_i), .rd_rid_i(rd_rid_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni     = 1'b0;
        req_i      = '0;
        rd_gnt_i   = 1'b0;
        addr_i     = {64'h0000_0000_0000_2000, 64'h0000_0000_0000_1000};
        blen_i     = {2'd3, 2'd1};
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
        rd_data_i  = '0;
        rd_rid_i   = '0;
        #3;
        check("rst_req",   rd_req_o,   1'b0);
        check("rst_busy",  busy_o,     1'b0);
        check("rst_gnt",   gnt_o,      2'b00);
        check("rst_err",   err_o,      1'b0);
        check("rst_valid", rd_valid_o, 2'b00);
        step();
        rst_ni = 1'b1;

        // Both requesting, shim always grants: grants alternate starting at requester 0.
        step();
        req_i = 2'b11; rd_gnt_i = 1'b1;
        #1;
        check("rr1_req",  rd_req_o,  1'b1);
        check("rr1_gnt",  gnt_o,     2'b01);
        check("rr1_id",   rd_id_o,   4'd0);
        check("rr1_addr", rd_addr_o, 64'h1000);
        check("rr1_blen", rd_blen_o, 2'd1);
        step(); #1;
        check("rr2_gnt",  gnt_o,     2'b10);
        check("rr2_id",   rd_id_o,   4'd1);
        check("rr2_addr", rd_addr_o, 64'h2000);
        check("rr2_blen", rd_blen_o, 2'd3);
        step(); #1;
        check("rr3_gnt", gnt_o,   2'b01);
        check("rr3_id",  rd_id_o, 4'd0);
        step(); #1;
        check("rr4_gnt", gnt_o,   2'b10);
        check("rr4_id",  rd_id_o, 4'd1);

        // Four in flight: the fifth request is throttled until a last beat returns.
        step(); #1;
        check("thr_req",  rd_req_o, 1'b0);
        check("thr_gnt",  gnt_o,    2'b00);
        check("thr_busy", busy_o,   1'b1);
        rd_valid_i = 1'b1; rd_last_i = 1'b1; rd_rid_i = 4'd0; rd_data_i = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("ret0_valid", rd_valid_o, 2'b01);
        check("ret0_data",  rd_data_o,  64'hDEAD_BEEF_0123_4567);
        check("ret0_last",  rd_last_o,  1'b1);
        check("ret0_req",   rd_req_o,   1'b0);

        // Count 3: grant and last beat together leave the count at 3.
        step();
        rd_rid_i = 4'd1;
        #1;
        check("same_req",   rd_req_o,   1'b1);
        check("same_gnt",   gnt_o,      2'b01);
        check("same_valid", rd_valid_o, 2'b10);
        step();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        #1;
        check("fill_gnt",  gnt_o,  2'b10);
        check("fill_busy", busy_o, 1'b1);
        step(); #1;
        check("full_req",  rd_req_o, 1'b0);
        check("full_busy", busy_o,   1'b1);

        // Drain all four bursts, then one stray last beat must not wrap the count.
        req_i = '0; rd_gnt_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            rd_valid_i = 1'b1; rd_last_i = 1'b1; rd_rid_i = 4'(k % 2);
        end
        step();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        #1;
        check("drain_busy", busy_o, 1'b0);
        rd_valid_i = 1'b1; rd_last_i = 1'b1;
        step();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        #1;
        check("under_busy", busy_o, 1'b0);
        req_i = 2'b01; rd_gnt_i = 1'b1;
        #1;
        check("under_gnt", gnt_o, 2'b01);
        step();
        req_i = '0; rd_gnt_i = 1'b0;
        #1;
        check("one_busy", busy_o, 1'b1);
        rd_valid_i = 1'b1; rd_last_i = 1'b1;
        step();
        rd_valid_i = 1'b0; rd_last_i = 1'b0;
        #1;
        check("zero_busy", busy_o, 1'b0);

        // Pointer now at 1; requester 0 waits three cycles, requester 1 joining must not steal it.
        req_i = 2'b01;
        #1;
        check("hold0_req",  rd_req_o,  1'b1);
        check("hold0_gnt",  gnt_o,     2'b00);
        check("hold0_addr", rd_addr_o, 64'h1000);
        for (int k = 1; k < 3; k++) begin
            step();
            req_i = 2'b11;
            #1;
            check("hold_req",  rd_req_o,  1'b1);
            check("hold_id",   rd_id_o,   4'd0);
            check("hold_addr", rd_addr_o, 64'h1000);
            check("hold_gnt",  gnt_o,     2'b00);
            check("hold_busy", busy_o,    1'b1);
        end
        step();
        rd_gnt_i = 1'b1;
        #1;
        check("hold3_req", rd_req_o, 1'b1);
        check("hold3_gnt", gnt_o,    2'b01);
        check("hold3_id",  rd_id_o,  4'd0);
        step();
        req_i = '0; rd_gnt_i = 1'b0;
        #1;
        check("post_req", rd_req_o, 1'b0);
        check("post_gnt", gnt_o,    2'b00);

        // ID routing and the sticky error for an ID outside the requester range.
        rd_valid_i = 1'b1; rd_rid_i = 4'd1;
        #1;
        check("id1_valid", rd_valid_o, 2'b10);
        check("id1_err",   err_o,      1'b0);
        rd_rid_i = 4'd3;
        #1;
        check("id3_valid", rd_valid_o, 2'b00);
        step();
        rd_valid_i = 1'b0;
        #1;
        check("err_set", err_o, 1'b1);
        step(); #1;
        check("err_sticky", err_o, 1'b1);

        // Asynchronous reset in the middle of a held request.
        req_i = 2'b10;
        step(); #1;
        check("pre_rst_req", rd_req_o, 1'b1);
        check("pre_rst_id",  rd_id_o,  4'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_req",  rd_req_o, 1'b0);
        check("arst_busy", busy_o,   1'b0);
        check("arst_gnt",  gnt_o,    2'b00);
        check("arst_err",  err_o,    1'b0);
        req_i = '0;
        step();
        rst_ni = 1'b1;
        #1;
        check("rel_busy", busy_o,   1'b0);
        check("rel_req",  rd_req_o, 1'b0);
        req_i = 2'b11; rd_gnt_i = 1'b1;
        #1;
        check("rel_rr_gnt", gnt_o, 2'b01);
        step();
        req_i = '0; rd_gnt_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
